// File: rtl/seg_scan_60_pkg.sv
// Shared types and constants for the seg_scan_60 display stage: converter
// states, 7-segment codes (active-high, bit order gfedcba) and the count limit.
package seg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int MAX_VAL = 59;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_60_bin2bcd_seq.sv
// Sequential double-dabble: LOAD latches the binary input, eight SHIFT cycles
// build the BCD digits, DONE flags them valid for one cycle.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  shift_cnt;
    logic [19:0] sreg;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] adj;
        adj = {add3(s[19:16]), add3(s[15:12]), add3(s[11:8]), s[7:0]};
        dabble_step = {adj[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == LOAD)
                shift_cnt <= 3'd0;
            else if (state == SHIFT)
                shift_cnt <= shift_cnt + 3'd1;
        end
    end

    // Datapath shift register needs no reset: it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == LOAD)
            sreg <= {12'd0, bin};
        else if (state == SHIFT)
            sreg <= dabble_step(sreg);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    assign hundreds = sreg[19:16];
    assign tens     = sreg[15:12];
    assign ones     = sreg[11:8];

endmodule

// File: rtl/seg_scan_60.sv
// Two-digit multiplexed 7-segment driver for a mod-60 count from a slow domain.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg_scan_60
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       err,
    output logic       busy
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [7:0]    v_s1;
    logic [7:0]    v_s2;
    logic [7:0]    last_conv;
    logic          stable;
    logic          start;
    logic          conv_busy;
    logic          conv_done;
    logic [3:0]    conv_h;
    logic [3:0]    conv_t;
    logic [3:0]    conv_o;
    logic [PW-1:0] presc;
    logic          sel;
    logic [6:0]    code;

    // A value is accepted only after two equal samples, so a count caught
    // mid-transition from the 1 Hz domain never reaches the converter.
    always_comb begin
        stable = (v_s1 == v_s2);
        start  = stable && (v_s2 != last_conv) && !conv_busy;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_s1      <= 8'd0;
            v_s2      <= 8'd0;
            last_conv <= 8'd0;
        end else begin
            v_s1 <= value;
            v_s2 <= v_s1;
            if (start)
                last_conv <= v_s2;
        end
    end

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (v_s2),
        .busy     (conv_busy),
        .done     (conv_done),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
            err      <= 1'b0;
        end else if (conv_done) begin
            if (conv_h != 4'd0 || conv_t > 4'(MAX_VAL / 10)) begin
                err      <= 1'b1;
                bcd_tens <= 4'hF;
                bcd_ones <= 4'hF;
            end else begin
                err      <= 1'b0;
                bcd_tens <= conv_t;
                bcd_ones <= conv_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            sel   <= 1'b0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            sel   <= ~sel;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // seg and an derive from registered state only, so both switch on the
    // same edge as the digit select.
    always_comb begin
        code = seg_code(bcd_ones);
        if (err)
            code = SEG_DASH;
        else if (sel) begin
`ifdef LEADING_ZERO_BLANK_EN
            code = (bcd_tens == 4'd0) ? SEG_BLANK : seg_code(bcd_tens);
`else
            code = seg_code(bcd_tens);
`endif
        end
        seg  = SEG_ACTIVE_LOW ? ~code : code;
        an   = SEG_ACTIVE_LOW ? ~(sel ? 2'b10 : 2'b01) : (sel ? 2'b10 : 2'b01);
        busy = conv_busy;
    end

endmodule

// File: tb/tb_seg_scan_60.sv
// Directed bench for seg_scan_60 (REFRESH_DIV=4, active-low outputs) with a
// queue of expected conversion results popped at the end of each conversion.
module tb_seg_scan_60;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       err;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    int         m_presc;
    logic       m_sel;
    logic       mon25 = 1'b0;
    logic       seen25 = 1'b0;

    always #5 clk = ~clk;

    seg_scan_60 #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .seg      (seg),
        .an       (an),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .err      (err),
        .busy     (busy)
    );

    // Reference digit-select: 4 cycles per digit, starting on ones after reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_presc <= 0;
            m_sel   <= 1'b0;
        end else if (m_presc == DIV - 1) begin
            m_presc <= 0;
            m_sel   <= ~m_sel;
        end else begin
            m_presc <= m_presc + 1;
        end
    end

    always @(negedge clk)
        if (mon25 && bcd_tens == 4'd2 && bcd_ones == 4'd5)
            seen25 <= 1'b1;

    function automatic logic [8:0] model(input int v);
        if (v > 59) return {1'b1, 8'hFF};
        return {1'b0, 4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d, input logic e);
        logic [6:0] c;
        case (d)
            4'd0: c = 7'h3F; 4'd1: c = 7'h06; 4'd2: c = 7'h5B; 4'd3: c = 7'h4F;
            4'd4: c = 7'h66; 4'd5: c = 7'h6D; 4'd6: c = 7'h7D; 4'd7: c = 7'h07;
            4'd8: c = 7'h7F; 4'd9: c = 7'h6F; default: c = 7'h00;
        endcase
        if (e) c = 7'h40;
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_value(input int v);
        value = 8'(v);
        exp_q.push_back(model(v));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tens"}, 32'(bcd_tens), 32'd0);
        check({tag, "_ones"}, 32'(bcd_ones), 32'd0);
        check({tag, "_err"},  32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_an"},   32'(an), 32'h2);
        check({tag, "_seg"},  32'(seg), 32'h40);
    endtask

    task automatic expect_conv(input string tag, output int nwait);
        int n;
        logic [8:0] e;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin tick(); n++; end
        nwait = n;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 20) begin tick(); n++; end
        check({tag, "_busy_len"}, 32'(n), 32'd10);
        check({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 32'({err, bcd_tens, bcd_ones}), 32'(e));
        end
    endtask

    task automatic check_display(input string tag, input logic [3:0] t, input logic [3:0] o,
                                 input logic e, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, "_an"}, 32'(an), m_sel ? 32'h1 : 32'h2);
            check({tag, "_seg"}, 32'(seg), 32'(exp_seg(m_sel ? t : o, e)));
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check(tag, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int nw;
        rst_n = 1'b0;
        value = 8'd37;

        // 1. reset state with a nonzero value present
        repeat (3) tick();
        check_reset("rst");

        // 2. first conversion after release: 37, then display scan
        rst_n = 1'b1;
        exp_q.push_back(model(37));
        expect_conv("c37", nw);
        check("c37_start_latency", 32'(nw), 32'd3);
        check_display("disp37", 4'd3, 4'd7, 1'b0, 12);

        // 3. wrap values
        push_value(59);
        expect_conv("c59", nw);
        push_value(0);
        expect_conv("c00", nw);

        // 4. out-of-range value shows dashes, then recovers
        push_value(60);
        expect_conv("c60", nw);
        check_display("disp60", 4'hF, 4'hF, 1'b1, 8);
        push_value(12);
        expect_conv("c12", nw);
        check_display("disp12", 4'd1, 4'd2, 1'b0, 4);

        // same value as last conversion: nothing starts
        check_idle("same_val_idle", 12);

        // 5. unstable input never starts a conversion; the settled value does, once
        for (int i = 0; i < 20; i++) begin
            value = 8'(30 + i);
            tick();
            check("toggle_idle", 32'(busy), 32'd0);
        end
        push_value(25);
        expect_conv("c25", nw);
        check_idle("after25_idle", 15);

        // 6. reset during the 4th SHIFT cycle of a conversion of 48
        push_value(48);
        nw = 0;
        while (busy !== 1'b1 && nw < 40) begin tick(); nw++; end
        check("c48_busy_rise", 32'(busy), 32'd1);
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check_reset("midrst");
        mon25 = 1'b1;
        rst_n = 1'b1;
        expect_conv("c48", nw);
        check("c48_restart_latency", 32'(nw), 32'd3);
        repeat (2) tick();
        check("no_stale_25", 32'(seen25), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_60.md
Name: seg_scan_60

Overview:
- Downstream display stage for the mod-60 seconds counter: consumes its 8-bit binary count (0..59) and drives a 2-digit multiplexed 7-segment display.
- Runs on the fast board clock. The count comes from the 1 Hz domain, so it is captured through a stability filter.
- A sequential double-dabble converter turns the captured count into BCD digits.
- A refresh prescaler alternates the two digit enables.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (≥2).
- SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low (common-anode); 0 = active-high.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- value  in  8  binary count from the mod-60 counter; asynchronous to clk.
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- an  out  2  digit enable; an[0] = ones, an[1] = tens.
- bcd_tens  out  4  registered tens digit.
- bcd_ones  out  4  registered ones digit.
- err  out  1  last converted value > 59.
- busy  out  1  converter active.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is synchronous and active-low, sampled only on posedge clk.
- Reset values:
  - v_s1 = v_s2 = last_conv = 0; FSM IDLE; prescaler 0; digit select = ones.
  - bcd_tens = bcd_ones = 0; err = 0; busy = 0.
  - an = ones enabled; seg = code "0" (polarity applied).
- Capture: v_s1 <= value; v_s2 <= v_s1 every cycle.
  - `stable` = (v_s1 == v_s2).
  - `start` = stable && (v_s2 != last_conv) && state == IDLE.
- Converter FSM:
  - IDLE → LOAD on start. LOAD latches v_s2 into the shift register and last_conv; busy = 1.
  - LOAD → SHIFT. SHIFT runs exactly 8 cycles; each cycle adds 3 to any BCD nibble ≥5, then shifts left 1.
  - SHIFT → DONE after the 8th shift.
  - DONE writes bcd_tens, bcd_ones and err, then returns to IDLE with busy = 0.
  - err = 1 if hundreds ≠ 0 or tens > 5. On err, bcd_tens = bcd_ones = 4'hF.
  - Latency: outputs update on the clk edge 10 cycles after the edge on which start is true.
  - busy is high for those 10 cycles.
- value changes while busy: ignored until IDLE, then re-evaluated normally. No lost final value.
- value equal to last_conv: no conversion.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit select toggles on the next edge.
  - an and seg update on the same edge.
  - Exactly one digit is enabled at all times.
- Segment encoding (active-high, gfedcba):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - dash = 40; blank = 00.
  - Both digits show dash when err = 1.
  - If SEG_ACTIVE_LOW = 1, both seg and an are bitwise inverted.
- Reset mid-conversion: FSM aborts to IDLE and all outputs return to reset values. Next stable value ≠ 0 starts a fresh conversion.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: tens digit shows blank when bcd_tens == 0 and err == 0. an still cycles normally.
- Undefined: tens digit always shows its code ("05" displayed for 5), as a clock display requires.

Decomposition:
- Package seg_pkg holds:
  - FSM state typedef {IDLE, LOAD, SHIFT, DONE}.
  - 7-segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - localparam MAX_VAL = 59.
- Sub-module bin2bcd_seq: double-dabble engine with start/busy/done, 8-bit in and hundreds/tens/ones out, FSM inside.
- Top-level seg_scan_60 keeps capture, err/last_conv, prescaler, mux and encoding.

Test Plan (bench uses REFRESH_DIV = 4, SEG_ACTIVE_LOW = 1, macro undefined):
1. Reset: rst_n low 3 cycles, value = 37 → bcd 0/0, err = 0, busy = 0, an = 2'b10, seg = 7'h40. Then release.
2. value held 37 after reset → start 2 cycles after release; busy for 10 cycles; bcd_tens = 3, bcd_ones = 7; seg alternates 7'h30 (tens) / 7'h78 (ones) every 4 cycles.
3. Wrap: value 59 then 0 → bcd 5/9, then 0/0. No err at either.
4. value = 60 → err = 1, bcd F/F, seg = 7'h3F on both digits. Then value = 12 → err clears, bcd 1/2.
5. value changes every cycle for 20 cycles, then holds 25 → busy stays 0 during toggling; exactly one conversion after the hold; result 2/5.
6. Assert rst_n low on the 4th SHIFT cycle of a conversion of 48 → outputs at reset values. After release with 48 held, 2/5 is never seen; final bcd 4/8.
